// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: two-requester write arbiter in front of a 16-entry
// register file, with a sequenced clear that walks all entries to zero.
//
// Optional feature: define REG_WRITE_ARB_RR_EN to resolve simultaneous
// requests round-robin (the requester not granted most recently wins).
// Without it, requester 0 always wins ties and no last-winner state exists.
//
// Handshake: reqN is a level request that the requester holds high until it
// sees gntN. gntN is combinational and the write of buswN to entry rwN
// commits at the same rising edge, so a requester drops reqN (or presents its
// next write) in the cycle after gntN was high.
//
// The FSM state is observable on busy (busy == state is CLEAR).

`default_nettype none

module reg_write_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [3:0]       rw0,
    input  logic [WIDTH-1:0] busw0,
    input  logic             req1,
    input  logic [3:0]       rw1,
    input  logic [WIDTH-1:0] busw1,
    input  logic             clr_start,
    input  logic [3:0]       ra,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [16];
    logic [WIDTH-1:0] mem_d [16];
    logic             prefer0;

`ifdef REG_WRITE_ARB_RR_EN
    // 1 means requester 1 won the last grant, so requester 0 wins the next tie.
    logic last_winner_q, last_winner_d;
    assign prefer0 = last_winner_q;
`else
    assign prefer0 = 1'b1;
`endif

    // Grants only in IDLE, never in reset, and never in the cycle a clear starts.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && (state_q == ST_IDLE) && !clr_start) begin
            if (req0 && (!req1 || prefer0)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Next-state: granted write in IDLE, or one zeroed entry per cycle in CLEAR.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
`ifdef REG_WRITE_ARB_RR_EN
        last_winner_d = last_winner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    ptr_d   = 4'd0;
                end else if (gnt0) begin
                    mem_d[rw0] = busw0;
`ifdef REG_WRITE_ARB_RR_EN
                    last_winner_d = 1'b0;
`endif
                end else if (gnt1) begin
                    mem_d[rw1] = busw1;
`ifdef REG_WRITE_ARB_RR_EN
                    last_winner_d = 1'b1;
`endif
                end
            end
            ST_CLEAR: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + 4'd1;
                if (ptr_q == 4'd15) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = 4'd0;
            end
        endcase
    end

    // State registers; reset clears every entry at once and aborts any clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
`ifdef REG_WRITE_ARB_RR_EN
            last_winner_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef REG_WRITE_ARB_RR_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    assign busy = (state_q == ST_CLEAR);
    assign q    = mem_q[ra];

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios push the expected grant
// (cycle number and grant vector) into a queue; a monitor pops one entry for
// every grant the DUT shows. Read data and busy are compared inline.
`timescale 1ns/1ps

module tb_reg_write_arbiter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1, clr_start;
  logic [3:0]       rw0, rw1, ra;
  logic [WIDTH-1:0] busw0, busw1;
  logic             gnt0, gnt1, busy;
  logic [WIDTH-1:0] q;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // {cycle[31:0], gnt1, gnt0}
  logic [33:0] exp_q[$];

  reg_write_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rw0(rw0), .busw0(busw0),
    .req1(req1), .rw1(rw1), .busw1(busw1),
    .clr_start(clr_start), .ra(ra),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .q(q)
  );

  // clock / cycle counter
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: every grant the DUT presents must match the head of the queue
  always @(negedge clk) begin : monitor
    logic [33:0] e;
    if (gnt0 || gnt1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", int'({gnt1, gnt0}), 0);
      end else begin
        e = exp_q.pop_front();
        check("grant_vector", int'({gnt1, gnt0}), int'(e[1:0]));
        check("grant_cycle", cyc, int'(e[33:2]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [1:0] g);
    exp_q.push_back({cyc[31:0], g});
  endtask

  task automatic read_chk(input logic [3:0] a, input int e, input string nm);
    ra = a;
    #1;
    check(nm, int'(q), e);
  endtask

  initial begin
    rst = 1'b1; clr_start = 1'b0;
    req0 = 1'b1; req1 = 1'b1;        // requests during reset must not be granted
    rw0 = 4'd0; rw1 = 4'd0; busw0 = '0; busw1 = '0; ra = 4'd0;

    // reset: all entries zero, busy low, no grants
    step();
    check("reset_busy", int'(busy), 0);
    for (int i = 0; i < 16; i++) begin
      read_chk(i[3:0], 0, "reset_entry");
      step();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

    // lone req0: immediate grant, old value until the edge, new value after
    req0 = 1'b1; rw0 = 4'd3; busw0 = 4'b1010;
    expect_grant(2'b01);
    read_chk(4'd3, 0, "rd_before_edge");
    check("idle_busy", int'(busy), 0);
    step();
    req0 = 1'b0;
    read_chk(4'd3, 10, "rd_after_write");
    step();

    // lone req1
    req1 = 1'b1; rw1 = 4'd7; busw1 = 4'd6;
    expect_grant(2'b10);
    step();
    req1 = 1'b0;
    read_chk(4'd7, 6, "lone_req1_write");
    step();

    // persistent tie for 4 cycles (last winner was requester 1)
    req0 = 1'b1; rw0 = 4'd1; busw0 = 4'd3;
    req1 = 1'b1; rw1 = 4'd2; busw1 = 4'd5;
    for (int k = 0; k < 4; k++) begin
`ifdef REG_WRITE_ARB_RR_EN
      if (k % 2 == 1) expect_grant(2'b10);
      else            expect_grant(2'b01);
`else
      expect_grant(2'b01);
`endif
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    read_chk(4'd1, 3, "tie_entry1");
    step();
`ifdef REG_WRITE_ARB_RR_EN
    read_chk(4'd2, 5, "tie_entry2");
`else
    read_chk(4'd2, 0, "tie_entry2");
`endif
    step();

    // same-address race: later grant overwrites
    req0 = 1'b1; rw0 = 4'd5; busw0 = 4'b0001;
    expect_grant(2'b01);
    step();
    req0 = 1'b0;
    req1 = 1'b1; rw1 = 4'd5; busw1 = 4'b1000;
    expect_grant(2'b10);
    read_chk(4'd5, 1, "race_first");
    step();
    req1 = 1'b0;
    read_chk(4'd5, 8, "race_second");
    step();

    // fill all entries with 1111, then clear with req1 stalled throughout
    for (int i = 0; i < 16; i++) begin
      req0 = 1'b1; rw0 = i[3:0]; busw0 = 4'b1111;
      expect_grant(2'b01);
      step();
    end
    req0 = 1'b0;
    read_chk(4'd9, 15, "fill_readback");
    step();
    clr_start = 1'b1;
    req1 = 1'b1; rw1 = 4'd9; busw1 = 4'd2;
    check("clr_start_busy", int'(busy), 0);
    step();
    for (int k = 1; k <= 16; k++) begin
      check("clear_busy", int'(busy), 1);
      clr_start = (k == 5);           // ignored while clearing
      step();
    end
    clr_start = 1'b0;
    expect_grant(2'b10);
    check("clear_done_busy", int'(busy), 0);
    step();
    req1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_chk(i[3:0], (i == 9) ? 2 : 0, "after_clear");
      step();
    end

    // clr_start together with req0: no grant now, grant when busy falls
    req0 = 1'b1; rw0 = 4'd4; busw0 = 4'd7;
    clr_start = 1'b1;
    check("sim_evt_busy", int'(busy), 0);
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("sim_evt_clear_busy", int'(busy), 1);
      step();
    end
    expect_grant(2'b01);
    check("sim_evt_done_busy", int'(busy), 0);
    step();
    req0 = 1'b0;
    read_chk(4'd4, 7, "sim_evt_write");
    step();

    // reset in the middle of a clear (pointer at 7)
    req0 = 1'b1; rw0 = 4'd12; busw0 = 4'hC;
    expect_grant(2'b01);
    step();
    req0 = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (7) step();
    check("pre_abort_busy", int'(busy), 1);
    rst = 1'b1;
    req0 = 1'b1; rw0 = 4'd0;  busw0 = 4'd9;
    req1 = 1'b1; rw1 = 4'd15; busw1 = 4'd4;
    step();
    check("rst_abort_busy", int'(busy), 0);
    read_chk(4'd12, 0, "rst_abort_entry");
    step();
    rst = 1'b0;
    expect_grant(2'b01);              // first tie after reset goes to requester 0
    step();
    req0 = 1'b0;
    expect_grant(2'b10);
    step();
    req1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_chk(i[3:0], (i == 0) ? 9 : ((i == 15) ? 4 : 0), "after_reset_abort");
      step();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
